// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause and EPC,
// plus exception entry/return handling and pipeline flush redirect.
module cp0_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [31:0] excptype,
  input  logic [31:0] pc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        timer_int,
  output logic        flush,
  output logic [31:0] flush_pc
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;

  localparam logic [31:0] EXC_TIMER   = 32'h0000_0004;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
  localparam logic [31:0] EXC_ERET    = 32'h0000_0200;
  localparam logic [31:0] EXC_VECTOR  = 32'h0000_0040;
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;

  logic exc_timer;
  logic exc_syscall;
  logic exc_eret;
  logic wr_en;
  logic count_match;

  assign exc_timer   = (excptype == EXC_TIMER);
  assign exc_syscall = (excptype == EXC_SYSCALL);
  assign exc_eret    = (excptype == EXC_ERET);
  // Any nonzero exception code squashes the instruction's own CP0 write.
  assign wr_en       = we && (excptype == 32'd0);
  assign count_match = (count_q == compare_q) && (compare_q != 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= 32'd0;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
    end else begin
      if (wr_en && waddr == REG_COUNT) count_q <= wdata;
      else                             count_q <= count_q + 32'd1;

      if (wr_en && waddr == REG_COMPARE) compare_q <= wdata;

      if (wr_en && waddr == REG_STATUS) status_q <= wdata & STATUS_MASK;
      if (exc_timer || exc_syscall) status_q[1] <= 1'b1;
      else if (exc_eret)            status_q[1] <= 1'b0;

      if (wr_en && waddr == REG_CAUSE) cause_q[9:8] <= wdata[9:8];
      // Compare write acknowledges the timer and beats a simultaneous match.
      if (wr_en && waddr == REG_COMPARE) cause_q[10] <= 1'b0;
      else if (count_match)              cause_q[10] <= 1'b1;
      if (exc_timer)        cause_q[6:2] <= 5'd0;
      else if (exc_syscall) cause_q[6:2] <= 5'd8;

      if (wr_en && waddr == REG_EPC) epc_q <= wdata;
      if (exc_timer)        epc_q <= pc;
      else if (exc_syscall) epc_q <= pc + 32'd4;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      REG_COUNT:   rdata = count_q;
      REG_COMPARE: rdata = compare_q;
      REG_STATUS:  rdata = status_q;
      REG_CAUSE:   rdata = cause_q;
      REG_EPC:     rdata = epc_q;
      default:     rdata = 32'd0;
    endcase
  end

  always_comb begin
    flush    = 1'b0;
    flush_pc = 32'd0;
    if (exc_timer || exc_syscall) begin
      flush    = 1'b1;
      flush_pc = EXC_VECTOR;
    end else if (exc_eret) begin
      flush    = 1'b1;
      flush_pc = epc_q;
    end
  end

  assign status    = status_q;
  assign cause     = cause_q;
  assign epc       = epc_q;
  assign timer_int = cause_q[10];

endmodule

// File: tb/tb_cp0_regs.sv
// Scoreboard bench for cp0_regs: stimulus pushes expected values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_cp0_regs;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [31:0] excptype;
  logic [31:0] pc;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        timer_int;
  logic        flush;
  logic [31:0] flush_pc;

  typedef enum logic [2:0] {
    SEL_RDATA, SEL_STATUS, SEL_CAUSE, SEL_EPC,
    SEL_TIMER_INT, SEL_FLUSH, SEL_FLUSH_PC
  } sel_t;

  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int compared   = 0;
  int mismatched = 0;

  cp0_regs dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .excptype(excptype), .pc(pc),
    .status(status), .cause(cause), .epc(epc), .timer_int(timer_int),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dut_value(sel_t s);
    case (s)
      SEL_RDATA:     return rdata;
      SEL_STATUS:    return status;
      SEL_CAUSE:     return cause;
      SEL_EPC:       return epc;
      SEL_TIMER_INT: return {31'd0, timer_int};
      SEL_FLUSH:     return {31'd0, flush};
      default:       return flush_pc;
    endcase
  endfunction

  // Monitor: everything queued during a cycle is checked at its falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      sb_entry_t e;
      logic [31:0] act;
      e   = sb_q.pop_front();
      act = dut_value(e.sel);
      compared++;
      if (act !== e.exp) begin
        mismatched++;
        $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic checkOutput(input string name, input sel_t sel, input logic [31:0] exp);
    sb_entry_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [31:0] exc, input logic [31:0] p);
    we       = w;
    waddr    = wa;
    wdata    = wd;
    excptype = exc;
    pc       = p;
  endtask

  task automatic readCheck(input string name, input logic [4:0] ra, input logic [31:0] exp);
    raddr = ra;
    checkOutput(name, SEL_RDATA, exp);
  endtask

  initial begin
    rst = 1'b1;
    raddr = 5'd14;
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick(2);

    // Held in reset: every address reads zero and nothing flushes.
    for (int r = 0; r < 32; r++) begin
      readCheck($sformatf("reset_rdata_%0d", r), r[4:0], 32'd0);
      tick(1);
    end
    checkOutput("reset_timer_int", SEL_TIMER_INT, 32'd0);
    checkOutput("reset_flush", SEL_FLUSH, 32'd0);
    checkOutput("reset_flush_pc", SEL_FLUSH_PC, 32'd0);
    tick(1);

    rst = 1'b0;
    tick(5);
    readCheck("count_after_5", 5'd9, 32'd5);
    checkOutput("idle_status", SEL_STATUS, 32'd0);
    checkOutput("idle_cause", SEL_CAUSE, 32'd0);
    checkOutput("idle_epc", SEL_EPC, 32'd0);

    // Timer: Compare=10, count reaches 10 three cycles after the two writes.
    applyStimulus(1'b1, 5'd11, 32'd10, 32'd0, 32'd0);
    tick(1);
    applyStimulus(1'b1, 5'd12, 32'h0000_0401, 32'd0, 32'd0);
    tick(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    readCheck("compare_rd", 5'd11, 32'd10);
    checkOutput("status_0401", SEL_STATUS, 32'h0000_0401);
    tick(3);
    readCheck("count_eq_cmp", 5'd9, 32'd10);
    checkOutput("ip2_not_yet", SEL_TIMER_INT, 32'd0);
    tick(1);
    checkOutput("ip2_set_cause", SEL_CAUSE, 32'h0000_0400);
    checkOutput("ip2_set_timer_int", SEL_TIMER_INT, 32'd1);
    readCheck("ip2_set_rdata", 5'd13, 32'h0000_0400);
    tick(1);
    applyStimulus(1'b1, 5'd11, 32'h20, 32'd0, 32'd0);
    tick(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    checkOutput("ip2_cleared_cause", SEL_CAUSE, 32'd0);
    checkOutput("ip2_cleared_timer_int", SEL_TIMER_INT, 32'd0);

    // Syscall entry.
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h100, 32'h0000_1000);
    checkOutput("sys_flush", SEL_FLUSH, 32'd1);
    checkOutput("sys_flush_pc", SEL_FLUSH_PC, 32'h40);
    tick(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h200, 32'd0);
    checkOutput("sys_epc", SEL_EPC, 32'h0000_1004);
    checkOutput("sys_status", SEL_STATUS, 32'h0000_0403);
    checkOutput("sys_cause", SEL_CAUSE, 32'h0000_0020);
    // Eret presented this cycle.
    checkOutput("eret_flush", SEL_FLUSH, 32'd1);
    checkOutput("eret_flush_pc", SEL_FLUSH_PC, 32'h0000_1004);
    tick(1);
    checkOutput("eret_status", SEL_STATUS, 32'h0000_0401);
    checkOutput("eret_epc", SEL_EPC, 32'h0000_1004);

    // Timer interrupt with a colliding EPC write that must be dropped.
    applyStimulus(1'b1, 5'd14, 32'hDEAD_BEEF, 32'h4, 32'h0000_0200);
    checkOutput("tint_flush", SEL_FLUSH, 32'd1);
    checkOutput("tint_flush_pc", SEL_FLUSH_PC, 32'h40);
    tick(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    checkOutput("tint_epc", SEL_EPC, 32'h0000_0200);
    checkOutput("tint_status", SEL_STATUS, 32'h0000_0403);
    checkOutput("tint_cause", SEL_CAUSE, 32'd0);
    checkOutput("idle_flush", SEL_FLUSH, 32'd0);
    checkOutput("idle_flush_pc", SEL_FLUSH_PC, 32'd0);
    tick(1);

    // Reads see the registered value, not a same-cycle write.
    applyStimulus(1'b1, 5'd14, 32'h0000_1234, 32'd0, 32'd0);
    readCheck("no_forward", 5'd14, 32'h0000_0200);
    tick(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    readCheck("epc_written", 5'd14, 32'h0000_1234);
    tick(1);

    // Count wrap.
    applyStimulus(1'b1, 5'd9, 32'hFFFF_FFFE, 32'd0, 32'd0);
    tick(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    readCheck("count_load", 5'd9, 32'hFFFF_FFFE);
    tick(2);
    readCheck("count_wrap", 5'd9, 32'd0);

    // Writable-bit masks and unimplemented registers.
    applyStimulus(1'b1, 5'd12, 32'hFFFF_FFFF, 32'd0, 32'd0);
    tick(1);
    applyStimulus(1'b1, 5'd13, 32'hFFFF_FFFF, 32'd0, 32'd0);
    checkOutput("status_mask", SEL_STATUS, 32'h0000_FF03);
    tick(1);
    applyStimulus(1'b1, 5'd5, 32'hA5A5_A5A5, 32'd0, 32'd0);
    checkOutput("cause_mask", SEL_CAUSE, 32'h0000_0300);
    tick(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    readCheck("unimpl_reg", 5'd5, 32'd0);
    tick(1);

    // Reset wins over a same-cycle syscall.
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 32'h100, 32'h0000_5000);
    tick(1);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    checkOutput("rst_exc_epc", SEL_EPC, 32'd0);
    checkOutput("rst_exc_status", SEL_STATUS, 32'd0);
    checkOutput("rst_exc_cause", SEL_CAUSE, 32'd0);
    tick(2);

    if (sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 we  in  1  register write enable, driven by the execute stage's cp0we.
REQ-005 waddr  in  5  write register number.
REQ-006 wdata  in  32  write data.
REQ-007 raddr  in  5  read register number; the execute stage defaults this to 14 (EPC).
REQ-008 rdata  out  32  combinational read data for raddr.
REQ-009 excptype  in  32  exception code from the execute stage: 0x4 = timer interrupt, 0x100 = syscall, 0x200 = eret, 0 = none.
REQ-010 pc  in  32  address of the instruction in the execute stage.
REQ-011 status  out  32  current Status register (reg 12).
REQ-012 cause  out  32  current Cause register (reg 13).
REQ-013 epc  out  32  current EPC register (reg 14).
REQ-014 timer_int  out  1  equals cause[10].
REQ-015 flush  out  1  combinational; 1 when excptype is 0x4, 0x100 or 0x200.
REQ-016 flush_pc  out  32  combinational redirect target: 0x0000_0040 for 0x4/0x100, current EPC for 0x200, 0 otherwise.

Function
REQ-017 Implemented registers: Count (9), Compare (11), Status (12), Cause (13), EPC (14).
REQ-018 Reads of any other address SHALL return 0; writes to them SHALL be ignored.
REQ-019 rdata SHALL return the registered value; a same-cycle write SHALL NOT be forwarded.
REQ-020 Count SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-021 A write to Count SHALL load wdata instead of incrementing in that cycle.
REQ-022 Status writable bits: [15:8] (IM) and [1:0] (EXL, IE); all other bits SHALL read 0.
REQ-023 Cause software-writable bits: [9:8] only; bit 10 (IP2) and [6:2] (ExcCode) are hardware-owned; all other bits SHALL read 0.
REQ-024 Timer match: when Count == Compare and Compare != 0, Cause[10] SHALL be set at the next edge.
REQ-025 A write to Compare SHALL clear Cause[10]; a clear SHALL win over a same-cycle match.
REQ-026 Timer interrupt (excptype 0x4), at the edge: EPC <= pc, Status[1] <= 1, Cause[6:2] <= 0.
REQ-027 Syscall (excptype 0x100), at the edge: EPC <= pc + 4 (modulo 2^32), Status[1] <= 1, Cause[6:2] <= 8.
REQ-028 Eret (excptype 0x200), at the edge: Status[1] <= 0; EPC is unchanged.
REQ-029 Any other excptype value SHALL be treated as none.
REQ-030 When excptype != 0, a same-cycle write (we=1) SHALL be dropped entirely, including Count and Compare.
REQ-031 Count SHALL increment regardless of exceptions.
REQ-032 The timer-match set of Cause[10] SHALL still occur during a timer-interrupt event; the interrupt does not auto-clear IP2.
REQ-033 Software SHALL clear IP2 only by writing Compare.
REQ-034 The block SHALL NOT gate interrupts itself; the masking qualification (IM2, EXL, IE) is done by the execute stage.

Reset
REQ-035 On rst=1 at a clock edge: Count, Compare, Status, Cause and EPC SHALL become 0; we and excptype are ignored in that cycle.
REQ-036 After reset: rdata = 0 for every raddr, timer_int = 0, flush = 0, flush_pc = 0.
REQ-037 A reset asserted during an exception cycle SHALL win; no EPC or Status update occurs.

Verification
REQ-038 Directed scenarios the bench SHALL cover (stimulus -> required response):
REQ-039 Reset, then idle 5 cycles -> Count reads 5; status = cause = epc = 0.
REQ-040 Write Compare=10, Status=0x0000_0401; hold until Count==10 -> cause[10]=1 on the next edge and timer_int=1; write Compare=0x20 -> cause[10]=0.
REQ-041 excptype=0x100 with pc=0x0000_1000 -> flush=1, flush_pc=0x40 in the same cycle; after the edge epc=0x1004, status[1]=1, cause[6:2]=8.
REQ-042 Then excptype=0x200 -> flush=1, flush_pc=0x1004; after the edge status[1]=0, epc still 0x1004.
REQ-043 we=1, waddr=14, wdata=0xDEAD_BEEF in the same cycle as excptype=0x4 with pc=0x200 -> epc=0x200 (write dropped).
REQ-044 Write Count=0xFFFF_FFFE, then idle 2 cycles -> Count=0; write Status=0xFFFF_FFFF -> status reads 0x0000_FF03.
